snes_joypad: RTL and testbench

SNES-pad front end for the Game Boy Color core. Periodically latches and serially clocks an SNES controller on the header GPIO pins and assembles the 16-bit serial response. It maps the result onto the eight Game Boy keys. It drives the active-low P10–P13 nibble the core's FF00 (P1) logic reads, and raises the joypad interrupt request.

---
 rtl/snes_joypad_pkg.sv | 55 +++++
 rtl/joypad_sync.sv | 25 ++
 rtl/snes_joypad.sv | 160 ++++++++++++++++
 tb/tb_snes_joypad.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_joypad_pkg.sv
// Shared definitions for the SNES pad front end: serial bit order,
// Game Boy key order, controller FSM states and the key mapping.
package snes_joypad_pkg;

    localparam int BIT_B      = 0;
    localparam int BIT_Y      = 1;
    localparam int BIT_SELECT = 2;
    localparam int BIT_START  = 3;
    localparam int BIT_UP     = 4;
    localparam int BIT_DOWN   = 5;
    localparam int BIT_LEFT   = 6;
    localparam int BIT_RIGHT  = 7;
    localparam int BIT_A      = 8;
    localparam int BIT_X      = 9;
    localparam int BIT_L      = 10;
    localparam int BIT_R      = 11;
    localparam int SNES_W     = BIT_R + 1;

    localparam int KEY_A      = 0;
    localparam int KEY_B      = 1;
    localparam int KEY_SELECT = 2;
    localparam int KEY_START  = 3;
    localparam int KEY_RIGHT  = 4;
    localparam int KEY_LEFT   = 5;
    localparam int KEY_UP     = 6;
    localparam int KEY_DOWN   = 7;

    localparam logic [SNES_W-1:0] UNMAPPED_MASK =
        (SNES_W'(1) << BIT_L) | (SNES_W'(1) << BIT_R);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    // {Down,Up,Left,Right,Start,Select,B,A}; X doubles A, Y doubles B
    function automatic logic [7:0] gb_keys(input logic [SNES_W-1:0] b);
        logic [SNES_W-1:0] m;
        logic [7:0]        k;
        m             = b & ~UNMAPPED_MASK;
        k             = '0;
        k[KEY_A]      = m[BIT_A] | m[BIT_X];
        k[KEY_B]      = m[BIT_B] | m[BIT_Y];
        k[KEY_SELECT] = m[BIT_SELECT];
        k[KEY_START]  = m[BIT_START];
        k[KEY_RIGHT]  = m[BIT_RIGHT];
        k[KEY_LEFT]   = m[BIT_LEFT];
        k[KEY_UP]     = m[BIT_UP];
        k[KEY_DOWN]   = m[BIT_DOWN];
        return k;
    endfunction

endpackage

// File: rtl/joypad_sync.sv
// Two-flop synchronizer for the asynchronous pad data line.
// Resets to 1 so an idle line reads as "released".
module joypad_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/snes_joypad.sv
// SNES controller poller feeding the Game Boy P1 nibble and joypad IRQ.
// Define JOYPAD_DEBOUNCE_EN to commit only two identical frames in a row.
module snes_joypad
    import snes_joypad_pkg::*;
#(
    parameter int POLL_PERIOD     = 550000,
    parameter int LATCH_CYCLES    = 396,
    parameter int HALF_BIT_CYCLES = 198
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ctrl_latch,
    output logic              ctrl_pulse,
    input  logic              ctrl_data,
    input  logic              p14,
    input  logic              p15,
    output logic [3:0]        joyp_in,
    output logic [SNES_W-1:0] snes_buttons,
    output logic              frame_valid,
    output logic              joypad_irq
);

    localparam int PW    = $clog2(POLL_PERIOD);
    localparam int PH_MX = (LATCH_CYCLES > HALF_BIT_CYCLES) ?
                           LATCH_CYCLES : HALF_BIT_CYCLES;
    localparam int PHW   = $clog2(PH_MX + 1);

    localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYCLES - 1);
    localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_BIT_CYCLES - 1);

    logic              data_s;
    logic [PW-1:0]     poll_q, poll_d;
    state_e            state_q, state_d;
    logic [PHW-1:0]    ph_q, ph_d;
    logic              hi_q, hi_d;
    logic [3:0]        bit_q, bit_d;
    logic [SNES_W-1:0] sr_q, sr_d;
    logic [SNES_W-1:0] btn_q, btn_d;
    logic              fv_q, fv_d;
    logic              irq_q, irq_d;
    logic              poll_wrap;
    logic              ph_end;
    logic              enter_commit;
    logic              take;
    logic [7:0]        gb;

    joypad_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (ctrl_data),
        .q_o   (data_s)
    );

    assign poll_wrap = (poll_q == POLL_LAST);
    assign poll_d    = poll_wrap ? '0 : poll_q + 1'b1;
    assign ph_end    = (state_q == ST_LATCH) ? (ph_q == LATCH_LAST)
                                             : (ph_q == HALF_LAST);

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q + 1'b1;
        hi_d         = hi_q;
        bit_d        = bit_q;
        sr_d         = sr_q;
        enter_commit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ph_d = '0;
                if (poll_wrap) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (ph_end) begin
                    state_d = ST_SHIFT;
                    ph_d    = '0;
                    hi_d    = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (ph_end) begin
                    ph_d = '0;
                    if (!hi_q) begin
                        // sample on the last low cycle; pad is active-low
                        hi_d = 1'b1;
                        if (bit_q < 4'd12) sr_d[bit_q] = ~data_s;
                    end else if (bit_q == 4'd15) begin
                        state_d      = ST_COMMIT;
                        hi_d         = 1'b0;
                        enter_commit = 1'b1;
                    end else begin
                        hi_d  = 1'b0;
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                ph_d    = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef JOYPAD_DEBOUNCE_EN
    logic [SNES_W-1:0] cand_q;

    assign take = (sr_q == cand_q);

    always_ff @(posedge clock) begin
        if (reset) cand_q <= '0;
        else if (enter_commit) cand_q <= sr_q;
    end
`else
    assign take = 1'b1;
`endif

    always_comb begin
        btn_d = btn_q;
        fv_d  = enter_commit;
        irq_d = 1'b0;
        if (enter_commit && take) begin
            btn_d = sr_q;
            irq_d = |(gb_keys(sr_q) & ~gb_keys(btn_q));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            poll_q  <= '0;
            state_q <= ST_IDLE;
            ph_q    <= '0;
            hi_q    <= 1'b0;
            bit_q   <= '0;
            sr_q    <= '0;
            btn_q   <= '0;
            fv_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            poll_q  <= poll_d;
            state_q <= state_d;
            ph_q    <= ph_d;
            hi_q    <= hi_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            btn_q   <= btn_d;
            fv_q    <= fv_d;
            irq_q   <= irq_d;
        end
    end

    assign gb           = gb_keys(btn_q);
    assign ctrl_latch   = (state_q == ST_LATCH);
    assign ctrl_pulse   = !((state_q == ST_SHIFT) && !hi_q);
    assign snes_buttons = btn_q;
    assign frame_valid  = fv_q;
    assign joypad_irq   = irq_q;
    assign joyp_in      = ~(({4{~p14}} & gb[7:4]) | ({4{~p15}} & gb[3:0]));

endmodule

// File: tb/tb_snes_joypad.sv
// Scoreboard bench for snes_joypad with a behavioural SNES pad.
// Build with JOYPAD_DEBOUNCE_EN to exercise the debounced variant.
module tb_snes_joypad;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_latch;
    logic        ctrl_pulse;
    logic        ctrl_data;
    logic        p14 = 1'b1;
    logic        p15 = 1'b1;
    logic [3:0]  joyp_in;
    logic [11:0] snes_buttons;
    logic        frame_valid;
    logic        joypad_irq;

    always #5 clock = ~clock;

    snes_joypad #(
        .POLL_PERIOD     (200),
        .LATCH_CYCLES    (4),
        .HALF_BIT_CYCLES (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ctrl_latch   (ctrl_latch),
        .ctrl_pulse   (ctrl_pulse),
        .ctrl_data    (ctrl_data),
        .p14          (p14),
        .p15          (p15),
        .joyp_in      (joyp_in),
        .snes_buttons (snes_buttons),
        .frame_valid  (frame_valid),
        .joypad_irq   (joypad_irq)
    );

    // pad: latch loads bit 0, each rising clock edge advances
    logic [11:0] pad = '0;
    logic [4:0]  idx = '0;

    always @(posedge ctrl_latch or posedge ctrl_pulse) begin
        if (ctrl_latch) idx <= '0;
        else if (idx < 5'd16) idx <= idx + 5'd1;
    end

    assign ctrl_data = (idx < 5'd12) ? ~pad[idx[3:0]] : 1'b1;

    typedef struct packed {
        logic [11:0] btn;
        logic        irq;
    } exp_t;

    exp_t        q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [11:0] m_btn      = '0;
`ifdef JOYPAD_DEBOUNCE_EN
    logic [11:0] m_cand     = '0;
`endif

    localparam logic [11:0] PB_B     = 12'h001;
    localparam logic [11:0] PB_Y     = 12'h002;
    localparam logic [11:0] PB_START = 12'h008;
    localparam logic [11:0] PB_UP    = 12'h010;
    localparam logic [11:0] PB_RIGHT = 12'h080;
    localparam logic [11:0] PB_A     = 12'h100;

    // {Down,Up,Left,Right,Start,Select,B,A}
    function automatic logic [7:0] gbk(input logic [11:0] b);
        return {b[5], b[4], b[6], b[7], b[3], b[2], b[0] | b[1], b[8] | b[9]};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_frame(input logic [11:0] cap);
        logic take;
        logic irq;
`ifdef JOYPAD_DEBOUNCE_EN
        take   = (cap == m_cand);
        m_cand = cap;
`else
        take   = 1'b1;
`endif
        irq = take && (|(gbk(cap) & ~gbk(m_btn)));
        if (take) m_btn = cap;
        q.push_back('{btn: m_btn, irq: irq});
    endtask

    task automatic chk_joyp(input logic s14, input logic s15);
        logic [7:0] g;
        logic [3:0] e;
        p14 = s14;
        p15 = s15;
        #1;
        g = gbk(m_btn);
        e = ~((s14 ? 4'h0 : g[7:4]) | (s15 ? 4'h0 : g[3:0]));
        check($sformatf("joyp_in p14=%0b p15=%0b", s14, s15), joyp_in, e);
    endtask

    task automatic wait_latch(input string nm, input int exp);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!ctrl_latch && n < 1000);
        check(nm, n, exp);
    endtask

    task automatic wait_fv();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_valid && n < 400);
        check("frame_seen", frame_valid, 1);
    endtask

    task automatic run_frame(input logic [11:0] v);
        @(posedge clock);
        pad = v;
        model_frame(v);
        wait_fv();
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (frame_valid) begin
                check("frame_expected", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("snes_buttons", snes_buttons, e.btn);
                    check("joypad_irq", joypad_irq, e.irq);
                end
            end else begin
                check("irq_without_frame", joypad_irq, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int lo;
        int falls;
        int len;
        int n;
        logic prev;

        p14 = 1'b0;
        p15 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset latch", ctrl_latch, 0);
        check("reset pulse", ctrl_pulse, 1);
        check("reset buttons", snes_buttons, 0);
        check("reset frame_valid", frame_valid, 0);
        check("reset irq", joypad_irq, 0);
        check("reset joyp_in", joyp_in, 4'hF);
        p14 = 1'b1;
        p15 = 1'b1;

        pad = '0;
        model_frame('0);
        @(negedge clock);
        reset = 1'b0;
        wait_latch("first_latch_cycle", 200);

        hi    = 1;
        lo    = 0;
        falls = 0;
        len   = 1;
        prev  = ctrl_pulse;
        while (!frame_valid && len < 1000) begin
            @(posedge clock);
            #1;
            len++;
            if (ctrl_latch) hi++;
            if (!ctrl_pulse) lo++;
            if (prev && !ctrl_pulse) falls++;
            prev = ctrl_pulse;
        end
        check("frame_length", len, 133);
        check("latch_width", hi, 4);
        check("low_cycles", lo, 64);
        check("pulse_count", falls, 16);

        run_frame(PB_A);
        chk_joyp(1'b1, 1'b0);
        chk_joyp(1'b1, 1'b1);
`ifdef JOYPAD_DEBOUNCE_EN
        run_frame(PB_A);
        chk_joyp(1'b1, 1'b0);
`endif

        run_frame(PB_UP | PB_RIGHT);
        chk_joyp(1'b0, 1'b1);
        run_frame(PB_UP | PB_RIGHT);
        chk_joyp(1'b0, 1'b1);
        chk_joyp(1'b0, 1'b0);

        run_frame(PB_Y);
        chk_joyp(1'b1, 1'b0);
`ifdef JOYPAD_DEBOUNCE_EN
        run_frame(PB_Y);
        chk_joyp(1'b1, 1'b0);
`endif
        p15 = 1'b1;

        // abort a frame during bit 7
        @(posedge clock);
        pad = PB_B;
        n   = 0;
        while (!ctrl_latch && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        falls = 0;
        prev  = ctrl_pulse;
        n     = 0;
        while (falls < 8 && n < 400) begin
            @(posedge clock);
            #1;
            n++;
            if (prev && !ctrl_pulse) falls++;
            prev = ctrl_pulse;
        end
        check("reached_bit7", falls, 8);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort latch", ctrl_latch, 0);
        check("abort pulse", ctrl_pulse, 1);
        check("abort buttons", snes_buttons, 0);
        m_btn = '0;
`ifdef JOYPAD_DEBOUNCE_EN
        m_cand = '0;
`endif
        @(negedge clock);
        reset = 1'b0;
        wait_latch("latch_after_reset", 200);
        model_frame(PB_B);
        wait_fv();
        chk_joyp(1'b1, 1'b0);

        run_frame(PB_START);
        chk_joyp(1'b1, 1'b0);
        run_frame('0);
        chk_joyp(1'b1, 1'b0);
        run_frame(PB_START);
        chk_joyp(1'b1, 1'b0);
        run_frame(PB_START);
        chk_joyp(1'b1, 1'b0);

        repeat (4) @(posedge clock);
        check("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
